pdemux: RTL and testbench
=========================

# pdemux

Registered priority demultiplexer: the steering counterpart of the `pmux` select network. It takes one input word with a select vector and a valid/ready handshake, and delivers the word to one of eight output lanes. Each lane has a single-entry holding register with its own valid/ready handshake. The block sits where a shared bus fans out to independent consumers and each consumer needs back-pressure.

## Interface
- `WIDTH`, 16, data word width in bits (lane count is fixed at 8)
- `clk_i`  in  1  clock; all state updates on the rising edge
- `rst_ni`  in  1  asynchronous active-low reset
- `data_i`  in  WIDTH  input word
- `sel_i`  in  8  lane select vector; bit k requests lane k
- `valid_i`  in  1  input word present
- `ready_o`  out  1  block can accept the input word this cycle
- `data_0_o` … `data_7_o`  out  WIDTH  lane holding registers
- `valid_o`  out  8  bit k: lane k holds a word
- `ready_i`  in  8  bit k: consumer k takes lane k's word this cycle
- `drop_cnt_o`  out  8  count of discarded words (see Configuration)

## Operation
- Target lane t is the lowest index k with `sel_i[k]`=1. Higher set bits are ignored, giving priority on the low index.
- If `sel_i`=0 there is no target. The word is accepted and discarded.
- `ready_o` is combinational:
  - 1 when `sel_i`=0;
  - otherwise `!valid_o[t] | ready_i[t]`.
- Accept means `valid_i & ready_o`.
- On accept with a target:
  - `data_t_o` ← `data_i`;
  - `valid_o[t]` ← 1.
- Lane drain is `valid_o[k] & ready_i[k]`. It clears `valid_o[k]` unless lane k is loaded in the same cycle.
- Drain and load on the same lane in the same cycle: the lane stays valid and now holds the new word. No bubble.
- `ready_i[k]` while `valid_o[k]`=0 has no effect.
- Data registers keep their value after drain; they are only written on load.
- Lanes are independent. Back-pressure on one lane never stalls words steered to other lanes.
- No combinational path from `data_i` to any `data_k_o`.

## Timing
- Reset (asynchronous assert, synchronous-safe release): all `data_k_o`=0, `valid_o`=0, `drop_cnt_o`=0.
- Reset asserted mid-transfer discards any held words immediately. The first accept is possible in the first edge after release.
- Latency: a word accepted at edge n appears on `data_t_o` with `valid_o[t]`=1 after edge n, i.e. one cycle.
- Throughput: one word per cycle into a lane whose consumer holds `ready_i` high.
- `ready_o` depends on `sel_i`, `valid_i`-independent state, and `ready_i`. It does not depend on `valid_i`.
- Handshake rule: upstream must hold `data_i` and `sel_i` stable while `valid_i`=1 and `ready_o`=0.

## Configuration
- `PDEMUX_DROP_CNT_EN` defined:
  - `drop_cnt_o` increments on every accept with `sel_i`=0;
  - it saturates at 255 and clears only on reset.
- `PDEMUX_DROP_CNT_EN` undefined:
  - the counter is not built and `drop_cnt_o` is tied to 0;
  - discard behaviour is otherwise identical.

## Test plan
- Single steer:
  - Stimulus: reset, then `data_i`=16'h1234, `sel_i`=8'b0000_0100, `valid_i`=1 for one cycle, `ready_i`=0.
  - Required: `ready_o`=1. Next cycle `valid_o`=8'h04 and `data_2_o`=16'h1234; all other data outputs 0.
- Priority:
  - Stimulus: `sel_i`=8'b1010_1000, `data_i`=16'hBEEF.
  - Required: only lane 3 loads (`valid_o`=8'h08, `data_3_o`=16'hBEEF).
- Back-pressure:
  - Stimulus: lane 2 full, `ready_i`=0, new word with `sel_i`=8'h04.
  - Required: `ready_o`=0 and `data_2_o` unchanged.
  - Stimulus: same cycle with `ready_i[2]`=1.
  - Required: `ready_o`=1; next cycle `valid_o[2]`=1 with the new word (drain+load, no bubble).
- Independence:
  - Stimulus: lane 0 full and stalled; words sent to lanes 1..7 on consecutive cycles.
  - Required: all are accepted (`ready_o`=1 each cycle); `valid_o`=8'hFF after 7 cycles.
- Drop counter (macro defined):
  - Stimulus: 300 accepts with `sel_i`=0.
  - Required: `drop_cnt_o`=255, `valid_o` unchanged.
  - Macro undefined: `drop_cnt_o`=0 throughout.
- Reset mid-operation:
  - Stimulus: `valid_o`=8'h5A with data held; assert `rst_ni`=0 asynchronously between edges.
  - Required: outputs go to 0 immediately. After release, a word with `sel_i`=8'h80 lands in lane 7 one cycle later.

Source files
------------

// File: rtl/pdemux_if.sv
// pdemux handshake bundle: upstream word/select and eight lane outputs.
// master is the upstream/consumer side, slave is the pdemux block.
interface pdemux_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] data_i;
  logic [7:0]       sel_i;
  logic             valid_i;
  logic             ready_o;
  logic [WIDTH-1:0] data_0_o;
  logic [WIDTH-1:0] data_1_o;
  logic [WIDTH-1:0] data_2_o;
  logic [WIDTH-1:0] data_3_o;
  logic [WIDTH-1:0] data_4_o;
  logic [WIDTH-1:0] data_5_o;
  logic [WIDTH-1:0] data_6_o;
  logic [WIDTH-1:0] data_7_o;
  logic [7:0]       valid_o;
  logic [7:0]       ready_i;
  logic [7:0]       drop_cnt_o;

  modport master (
    output data_i, sel_i, valid_i, ready_i,
    input  ready_o, valid_o, drop_cnt_o,
    input  data_0_o, data_1_o, data_2_o, data_3_o,
    input  data_4_o, data_5_o, data_6_o, data_7_o
  );

  modport slave (
    input  data_i, sel_i, valid_i, ready_i,
    output ready_o, valid_o, drop_cnt_o,
    output data_0_o, data_1_o, data_2_o, data_3_o,
    output data_4_o, data_5_o, data_6_o, data_7_o
  );
endinterface

// File: rtl/pdemux.sv
// Registered priority demux into eight single-entry lanes.
// Optional discard counter enabled by PDEMUX_DROP_CNT_EN.
module pdemux #(
  parameter int WIDTH = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  pdemux_if.slave     bus
);

  logic [WIDTH-1:0] data_q [8];
  logic [7:0]       valid_q;
  logic [7:0]       onehot;
  logic [7:0]       load;
  logic             has_tgt;
  logic             ready;
  logic             accept;

  // Isolate lowest set bit: low lane wins.
  always_comb begin
    onehot  = bus.sel_i & (~bus.sel_i + 8'd1);
    has_tgt = |bus.sel_i;
    ready   = !has_tgt ||
              (|(onehot & (~valid_q | bus.ready_i)));
    accept  = bus.valid_i && ready;
    load    = accept ? onehot : 8'd0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 8'd0;
      for (int k = 0; k < 8; k++)
        data_q[k] <= '0;
    end else begin
      valid_q <= load | (valid_q & ~bus.ready_i);
      for (int k = 0; k < 8; k++)
        if (load[k])
          data_q[k] <= bus.data_i;
    end
  end

`ifdef PDEMUX_DROP_CNT_EN
  logic [7:0] drop_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      drop_q <= 8'd0;
    else if (accept && !has_tgt && drop_q != 8'hFF)
      drop_q <= drop_q + 8'd1;
  end

  assign bus.drop_cnt_o = drop_q;
`else
  assign bus.drop_cnt_o = 8'd0;
`endif

  assign bus.ready_o  = ready;
  assign bus.valid_o  = valid_q;
  assign bus.data_0_o = data_q[0];
  assign bus.data_1_o = data_q[1];
  assign bus.data_2_o = data_q[2];
  assign bus.data_3_o = data_q[3];
  assign bus.data_4_o = data_q[4];
  assign bus.data_5_o = data_q[5];
  assign bus.data_6_o = data_q[6];
  assign bus.data_7_o = data_q[7];

endmodule

// File: tb/tb_pdemux.sv
// Directed self-checking bench for pdemux.
// Drives on negedge, samples 1 time unit after edges.
module tb_pdemux;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  pdemux_if #(.WIDTH(16)) bus ();

  pdemux #(.WIDTH(16)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] lane(input int k);
    unique case (k)
      0: lane = bus.data_0_o;
      1: lane = bus.data_1_o;
      2: lane = bus.data_2_o;
      3: lane = bus.data_3_o;
      4: lane = bus.data_4_o;
      5: lane = bus.data_5_o;
      6: lane = bus.data_6_o;
      default: lane = bus.data_7_o;
    endcase
  endfunction

  task automatic idle();
    bus.data_i  = 16'h0;
    bus.sel_i   = 8'h0;
    bus.valid_i = 1'b0;
    bus.ready_i = 8'h0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send(input logic [7:0] s, input logic [15:0] d);
    @(negedge clk);
    bus.sel_i   = s;
    bus.data_i  = d;
    bus.valid_i = 1'b1;
    @(posedge clk);
    #1;
    bus.valid_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    total++;
    if (bus.valid_o !== 8'h00) begin
      bad++;
      $display("FAIL reset_valid got=%h exp=00", bus.valid_o);
    end
    total++;
    if (bus.drop_cnt_o !== 8'h00) begin
      bad++;
      $display("FAIL reset_drop got=%h exp=00", bus.drop_cnt_o);
    end
    for (int k = 0; k < 8; k++) begin
      total++;
      if (lane(k) !== 16'h0) begin
        bad++;
        $display("FAIL reset_data%0d got=%h exp=0000", k, lane(k));
      end
    end
  endtask

  task automatic test_single_steer();
    do_reset();
    @(negedge clk);
    bus.data_i  = 16'h1234;
    bus.sel_i   = 8'b0000_0100;
    bus.valid_i = 1'b1;
    #1;
    total++;
    if (bus.ready_o !== 1'b1) begin
      bad++;
      $display("FAIL steer_ready got=%b exp=1", bus.ready_o);
    end
    @(posedge clk);
    #1;
    bus.valid_i = 1'b0;
    total++;
    if (bus.valid_o !== 8'h04) begin
      bad++;
      $display("FAIL steer_valid got=%h exp=04", bus.valid_o);
    end
    for (int k = 0; k < 8; k++) begin
      logic [15:0] e;
      e = (k == 2) ? 16'h1234 : 16'h0;
      total++;
      if (lane(k) !== e) begin
        bad++;
        $display("FAIL steer_data%0d got=%h exp=%h", k, lane(k), e);
      end
    end
  endtask

  task automatic test_priority();
    do_reset();
    send(8'b1010_1000, 16'hBEEF);
    total++;
    if (bus.valid_o !== 8'h08) begin
      bad++;
      $display("FAIL prio_valid got=%h exp=08", bus.valid_o);
    end
    total++;
    if (bus.data_3_o !== 16'hBEEF) begin
      bad++;
      $display("FAIL prio_data3 got=%h exp=beef", bus.data_3_o);
    end
    total++;
    if (bus.data_5_o !== 16'h0 || bus.data_7_o !== 16'h0) begin
      bad++;
      $display("FAIL prio_hi got=%h/%h exp=0/0",
               bus.data_5_o, bus.data_7_o);
    end
  endtask

  task automatic test_back_pressure();
    do_reset();
    send(8'h04, 16'h1111);
    @(negedge clk);
    bus.sel_i   = 8'h04;
    bus.data_i  = 16'h2222;
    bus.valid_i = 1'b1;
    bus.ready_i = 8'h00;
    #1;
    total++;
    if (bus.ready_o !== 1'b0) begin
      bad++;
      $display("FAIL bp_stall_ready got=%b exp=0", bus.ready_o);
    end
    @(posedge clk);
    #1;
    total++;
    if (bus.data_2_o !== 16'h1111 || bus.valid_o !== 8'h04) begin
      bad++;
      $display("FAIL bp_hold got=%h/%h exp=1111/04",
               bus.data_2_o, bus.valid_o);
    end
    @(negedge clk);
    bus.ready_i = 8'h04;
    #1;
    total++;
    if (bus.ready_o !== 1'b1) begin
      bad++;
      $display("FAIL bp_pass_ready got=%b exp=1", bus.ready_o);
    end
    @(posedge clk);
    #1;
    bus.valid_i = 1'b0;
    total++;
    if (bus.data_2_o !== 16'h2222 || bus.valid_o !== 8'h04) begin
      bad++;
      $display("FAIL bp_nobubble got=%h/%h exp=2222/04",
               bus.data_2_o, bus.valid_o);
    end
    @(posedge clk);
    #1;
    total++;
    if (bus.valid_o !== 8'h00 || bus.data_2_o !== 16'h2222) begin
      bad++;
      $display("FAIL bp_drain got=%h/%h exp=00/2222",
               bus.valid_o, bus.data_2_o);
    end
    bus.ready_i = 8'h00;
  endtask

  task automatic test_independence();
    do_reset();
    send(8'h01, 16'hA000);
    for (int k = 1; k < 8; k++) begin
      @(negedge clk);
      bus.sel_i   = 8'(1 << k);
      bus.data_i  = 16'hA000 + 16'(k);
      bus.valid_i = 1'b1;
      #1;
      total++;
      if (bus.ready_o !== 1'b1) begin
        bad++;
        $display("FAIL indep_ready%0d got=%b exp=1", k, bus.ready_o);
      end
    end
    @(posedge clk);
    #1;
    bus.valid_i = 1'b0;
    total++;
    if (bus.valid_o !== 8'hFF) begin
      bad++;
      $display("FAIL indep_valid got=%h exp=ff", bus.valid_o);
    end
    for (int k = 0; k < 8; k++) begin
      total++;
      if (lane(k) !== 16'hA000 + 16'(k)) begin
        bad++;
        $display("FAIL indep_data%0d got=%h exp=%h",
                 k, lane(k), 16'hA000 + 16'(k));
      end
    end
  endtask

  task automatic test_drop();
    logic [7:0] e100;
    logic [7:0] e300;
`ifdef PDEMUX_DROP_CNT_EN
    e100 = 8'd100;
    e300 = 8'd255;
`else
    e100 = 8'd0;
    e300 = 8'd0;
`endif
    do_reset();
    send(8'h02, 16'h5555);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      bus.sel_i   = 8'h00;
      bus.data_i  = 16'(i);
      bus.valid_i = 1'b1;
      if (i == 100) begin
        total++;
        if (bus.drop_cnt_o !== e100) begin
          bad++;
          $display("FAIL drop_mid got=%0d exp=%0d",
                   bus.drop_cnt_o, e100);
        end
      end
    end
    @(posedge clk);
    #1;
    bus.valid_i = 1'b0;
    total++;
    if (bus.drop_cnt_o !== e300) begin
      bad++;
      $display("FAIL drop_sat got=%0d exp=%0d", bus.drop_cnt_o, e300);
    end
    total++;
    if (bus.valid_o !== 8'h02 || bus.data_1_o !== 16'h5555) begin
      bad++;
      $display("FAIL drop_lanes got=%h/%h exp=02/5555",
               bus.valid_o, bus.data_1_o);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send(8'h02, 16'h0101);
    send(8'h08, 16'h0303);
    send(8'h10, 16'h0404);
    send(8'h40, 16'h0606);
    total++;
    if (bus.valid_o !== 8'h5A) begin
      bad++;
      $display("FAIL mid_pre got=%h exp=5a", bus.valid_o);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.valid_o !== 8'h00 || bus.drop_cnt_o !== 8'h00) begin
      bad++;
      $display("FAIL mid_async got=%h/%h exp=00/00",
               bus.valid_o, bus.drop_cnt_o);
    end
    for (int k = 0; k < 8; k++) begin
      total++;
      if (lane(k) !== 16'h0) begin
        bad++;
        $display("FAIL mid_data%0d got=%h exp=0000", k, lane(k));
      end
    end
    @(negedge clk);
    rst_n       = 1'b1;
    bus.sel_i   = 8'h80;
    bus.data_i  = 16'hABCD;
    bus.valid_i = 1'b1;
    @(posedge clk);
    #1;
    bus.valid_i = 1'b0;
    total++;
    if (bus.valid_o !== 8'h80 || bus.data_7_o !== 16'hABCD) begin
      bad++;
      $display("FAIL mid_after got=%h/%h exp=80/abcd",
               bus.valid_o, bus.data_7_o);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    idle();
    test_reset();
    test_single_steer();
    test_priority();
    test_back_pressure();
    test_independence();
    test_drop();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
